// File: rtl/matrix_pixel_fetch.sv
// matrix_pixel_fetch: framebuffer and scan sequencer feeding the HUB75 line driver.
// Streams one BCM bit-plane of one row pair (top and bottom halves together) per line,
// then waits for the driver's line_ack before stepping plane -> row -> frame.
// Optional macro DOUBLE_BUFFER_EN: front/back framebuffer sets with swap_req/swap_done.
module matrix_pixel_fetch #(
  parameter  int COLS = 32,
  parameter  int ROWS = 16,
  parameter  int BPC  = 4,
  localparam int CW   = $clog2(COLS),
  localparam int RW   = $clog2(ROWS),
  localparam int PW   = (BPC > 1) ? $clog2(BPC) : 1,
  localparam int DW   = 3 * BPC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              wr_en,
  input  logic [RW+CW:0]    wr_addr,
  input  logic [DW-1:0]     wr_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [1:0]        pix_r,
  output logic [1:0]        pix_g,
  output logic [1:0]        pix_b,
  output logic              pix_last,
  output logic [RW-1:0]     line_row,
  output logic [PW-1:0]     line_plane,
  input  logic              line_ack,
  output logic              frame_start,
`ifdef DOUBLE_BUFFER_EN
  input  logic              swap_req,
  output logic              swap_done,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM, WAIT_ACK} state_t;

  state_t              state;
  logic [CW-1:0]       rd_col;
  logic                re;
  logic                last_plane, last_row, wrap;
  logic [1:0]          bank_we;
  logic [1:0][DW-1:0]  rdata;

  assign last_plane = (line_plane == PW'(BPC - 1));
  assign last_row   = (line_row == RW'(ROWS - 1));
  assign wrap       = last_plane && last_row;
  assign busy       = (state != IDLE);

  // FETCH primes column 0; in STREAM the output register only reloads when it is
  // empty or being consumed, and never past the last column of the line.
  assign re = (state == FETCH) ||
              ((state == STREAM) && (!pix_valid || pix_ready) && !pix_last);

`ifdef DOUBLE_BUFFER_EN
  localparam int AW = RW + CW + 1;
  logic          front, swap_pend, swap_now;
  logic [AW-1:0] raddr, waddr;

  // Scan reads the front set, host writes land in the back set.
  assign raddr    = {front, line_row, rd_col};
  assign waddr    = {~front, wr_addr[RW+CW-1:0]};
  assign swap_now = swap_pend &&
                    ((state == IDLE) || ((state == WAIT_ACK) && line_ack && wrap));

  // Sticky swap request, consumed at the next frame wrap or at once when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front     <= 1'b0;
      swap_pend <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      swap_done <= swap_now;
      if (swap_now) front <= ~front;
      swap_pend <= swap_req || (swap_pend && !swap_now);
    end
  end
`else
  localparam int AW = RW + CW;
  logic [AW-1:0] raddr, waddr;

  assign raddr = {line_row, rd_col};
  assign waddr = wr_addr[RW+CW-1:0];
`endif

  // Two banks: index 0 = top half (y < ROWS), index 1 = bottom half.
  for (genvar h = 0; h < 2; h++) begin : g_bank
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] q;
    logic [BPC-1:0] ch_r, ch_g, ch_b;

    assign bank_we[h] = wr_en && (wr_addr[RW+CW] == 1'(h));

    // Host write port; storage has no reset so contents survive rst.
    always_ff @(posedge clk) begin
      if (bank_we[h]) mem[waddr] <= wr_data;
    end

    // Read register: read-first on address collision, holds while re is low.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)     q <= '0;
      else if (re) q <= mem[raddr];
    end

    assign rdata[h] = q;
    assign ch_r     = q[3*BPC-1 -: BPC];
    assign ch_g     = q[2*BPC-1 -: BPC];
    assign ch_b     = q[BPC-1:0];
    assign pix_r[h] = ch_r[line_plane];
    assign pix_g[h] = ch_g[line_plane];
    assign pix_b[h] = ch_b[line_plane];
  end

  // Scan sequencer: line fetch/stream handshake, ack wait, plane/row/frame stepping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rd_col      <= '0;
      pix_valid   <= 1'b0;
      pix_last    <= 1'b0;
      line_row    <= '0;
      line_plane  <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (re) begin
        rd_col   <= rd_col + 1'b1;
        pix_last <= (rd_col == CW'(COLS - 1));
      end
      case (state)
        IDLE: begin
          if (run) begin
            state       <= FETCH;
            frame_start <= (line_row == '0) && (line_plane == '0);
          end
        end
        FETCH: begin
          state     <= STREAM;
          pix_valid <= 1'b1;
        end
        STREAM: begin
          if (pix_valid && pix_ready && pix_last) begin
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            state     <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (line_ack) begin
            if (last_plane) begin
              line_plane <= '0;
              line_row   <= last_row ? '0 : line_row + 1'b1;
            end else begin
              line_plane <= line_plane + 1'b1;
            end
            state       <= run ? FETCH : IDLE;
            frame_start <= run && wrap;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_pixel_fetch.sv
// Directed bench for matrix_pixel_fetch (COLS=32, ROWS=16, BPC=4).
// A bench-side copy of the framebuffer supplies expected pixel bits.
module tb_matrix_pixel_fetch;
  localparam int COLS = 32, ROWS = 16, BPC = 4;

  logic clk = 1'b0;
  logic rst, run, wr_en, pix_valid, pix_ready, pix_last, line_ack, frame_start, busy;
  logic [9:0]  wr_addr;
  logic [11:0] wr_data;
  logic [1:0]  pix_r, pix_g, pix_b;
  logic [3:0]  line_row;
  logic [1:0]  line_plane;
`ifdef DOUBLE_BUFFER_EN
  logic swap_req, swap_done;
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int fb = 0;                                // expected front buffer index
  logic [11:0] mir [2][2][ROWS][COLS];       // [buffer][bank][row][col]

  always #5 clk = ~clk;

  matrix_pixel_fetch #(.COLS(COLS), .ROWS(ROWS), .BPC(BPC)) dut (
    .clk(clk), .rst(rst), .run(run), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_last(pix_last), .line_row(line_row), .line_plane(line_plane), .line_ack(line_ack),
    .frame_start(frame_start),
`ifdef DOUBLE_BUFFER_EN
    .swap_req(swap_req), .swap_done(swap_done),
`endif
    .busy(busy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] pat(input int bank, input int y, input int x);
    logic [3:0] a, b;
    a = 4'(x);
    b = 4'(y);
    return (bank != 0) ? {~a, a ^ b, b} : {a, b, a + b};
  endfunction

  function automatic logic [5:0] exp_pix(input int r, input int p, input int x);
    logic [11:0] t, b;
    t = mir[fb][0][r][x];
    b = mir[fb][1][r][x];
    return {b[8+p], t[8+p], b[4+p], t[4+p], b[p], t[p]};
  endfunction

  task automatic wr(input int bank, input int y, input int x, input logic [11:0] d);
    wr_en   = 1'b1;
    wr_addr = {5'(bank * ROWS + y), 5'(x)};
    wr_data = d;
    tick;
    wr_en = 1'b0;
    mir[DB ? 1 - fb : fb][bank][y][x] = d;
  endtask

  task automatic fill;
    for (int b = 0; b < 2; b++)
      for (int y = 0; y < ROWS; y++)
        for (int x = 0; x < COLS; x++)
          wr(b, y, x, pat(b, y, x));
    wr(0, 0, 0, 12'hF00);   // top(0,0): r=F
    wr(1, 0, 0, 12'h010);   // bottom(16,0): g=1
  endtask

  // Consume one line; optional stall column, read/write collision column, reset column.
  task automatic stream_line(input int er, input int ep, input int stall_col,
                             input int raw_col, input int rst_col);
    int col = 0, st = 0, g = 0;
    bit raw_pend = 1'b0;
    logic [11:0] raw_d = '0;
    while (pix_valid !== 1'b1 && g < 8) begin tick; g++; end
    chk("line_start_valid", pix_valid, 1);
    while (col < COLS) begin
      chk("valid", pix_valid, 1);
      chk("pix", {pix_r, pix_g, pix_b}, exp_pix(er, ep, col));
      chk("last", pix_last, col == COLS - 1);
      chk("row", line_row, er);
      chk("plane", line_plane, ep);
      chk("fs_low", frame_start, 0);
      if (col == rst_col) begin
        rst = 1'b1;
        #1;
        chk("rst_valid", pix_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_row", line_row, 0);
        chk("rst_plane", line_plane, 0);
        return;
      end
      pix_ready = !(col == stall_col && st < 5);
      if (!pix_ready) st++;
      if (col == raw_col - 1 && pix_ready) begin
        wr_en    = 1'b1;
        wr_addr  = {5'd0, 5'(raw_col)};
        wr_data  = ~mir[fb][0][0][raw_col];
        raw_d    = wr_data;
        raw_pend = 1'b1;
      end
      tick;
      wr_en = 1'b0;
      if (pix_ready) col++;
    end
    pix_ready = 1'b1;
    chk("valid_drop", pix_valid, 0);
    if (raw_pend) mir[DB ? 1 - fb : fb][0][0][raw_col] = raw_d;
  endtask

  task automatic do_ack(input bit exp_fs);
    chk("ack_wait_valid", pix_valid, 0);
    chk("ack_wait_busy", busy, 1);
    tick;
    line_ack = 1'b1;
    tick;
    line_ack = 1'b0;
    chk("frame_start", frame_start, exp_fs);
  endtask

  task automatic run_frame_rest(input bit exp_swap);
    for (int i = 1; i < ROWS * BPC; i++) begin
      do_ack(1'b0);
      stream_line(i / BPC, i % BPC, -1, -1, -1);
    end
    do_ack(1'b1);
`ifdef DOUBLE_BUFFER_EN
    chk("swap_done", swap_done, exp_swap);
`endif
    if (exp_swap) fb = 1 - fb;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    pix_ready = 1'b1; line_ack = 1'b0;
`ifdef DOUBLE_BUFFER_EN
    swap_req = 1'b0;
`endif
    #12;
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_busy0", busy, 0);
    chk("rst_line_row", line_row, 0);
    chk("rst_line_plane", line_plane, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_pix_last", pix_last, 0);
    chk("rst_pix", {pix_r, pix_g, pix_b}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    fill();
`ifdef DOUBLE_BUFFER_EN
    swap_req = 1'b1; tick; swap_req = 1'b0;
    chk("idle_swap_pending", swap_done, 0);
    tick;
    chk("idle_swap_done", swap_done, 1);
    fb = 1;
    tick;
    chk("idle_swap_pulse", swap_done, 0);
    fill();
`endif

    // First line: latency 2, hand-computed column 0, stall at column 7.
    run = 1'b1;
    tick;
    chk("first_fs", frame_start, 1);
    chk("first_busy", busy, 1);
    chk("first_latency1", pix_valid, 0);
    tick;
    chk("first_latency2", pix_valid, 1);
    chk("first_r", pix_r, 2'b01);
    chk("first_g", pix_g, 2'b10);
    chk("first_b", pix_b, 2'b00);
    stream_line(0, 0, 7, -1, -1);
    run_frame_rest(1'b0);

    // Frame 2: write x=3 while the scan reads it; next line sees the new value.
    stream_line(0, 0, -1, 3, -1);
    do_ack(1'b0);
    run = 1'b0;
    stream_line(0, 1, -1, -1, -1);
    do_ack(1'b0);
    chk("stop_busy", busy, 0);
    chk("stop_plane", line_plane, 2);
    tick;
    chk("stop_valid", pix_valid, 0);
    line_ack = 1'b1; tick; line_ack = 1'b0;
    chk("idle_ack_plane", line_plane, 2);
    chk("idle_ack_busy", busy, 0);

    // Restart mid-frame, then reset at column 12.
    run = 1'b1;
    tick;
    chk("resume_fs", frame_start, 0);
    chk("resume_busy", busy, 1);
    stream_line(0, 2, -1, -1, 12);
    fb = 0;
    tick;
    rst = 1'b0;
    tick;
    chk("restart_fs", frame_start, 1);
    stream_line(0, 0, -1, -1, -1);

`ifdef DOUBLE_BUFFER_EN
    wr(0, 0, 5, ~mir[1 - fb][0][0][5]);
    swap_req = 1'b1; tick; swap_req = 1'b0;
    chk("mid_swap_none", swap_done, 0);
    run_frame_rest(1'b1);
    stream_line(0, 0, -1, -1, -1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
